// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard sequencer of the 5-stage MIPS core:
// the sequencer FSM state type, the MIPS opcodes the decoder classifies, the
// register-specifier and counter widths, and the bit positions of the
// control bundle that flows down ID/EX, EX/MEM and MEM/WB.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  // Sequencer state: RUN is normal flow, MISS_WAIT holds the pipeline frozen
  // until the data cache returns the refill.
  typedef enum logic [0:0] {
    RUN       = 1'b0,
    MISS_WAIT = 1'b1
  } state_e;

  // Opcodes used by the ID decoder to build the opcode-class inputs.
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;

  // Control bundle layout; a NOP is the all-zero bundle.
  localparam int CB_WB_HI = 8;
  localparam int CB_WB_LO = 7;
  localparam int CB_M_HI  = 6;
  localparam int CB_M_LO  = 4;
  localparam int CB_EX_HI = 3;
  localparam int CB_EX_LO = 0;
  localparam int CB_W     = 9;

  // True for the opcodes whose instruction reads rt as a source.
  function automatic logic op_reads_rt(input logic [5:0] op);
    logic r_s;
    case (op)
      6'h00:   r_s = 1'b1;
      OP_BEQ:  r_s = 1'b1;
      OP_BNE:  r_s = 1'b1;
      OP_SW:   r_s = 1'b1;
      default: r_s = 1'b0;
    endcase
    return r_s;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard sequencer.
//   Status into the sequencer: id_j, id_rs, id_rt, id_uses_rt, ex_memread,
//     ex_rt, mem_access, dcache_hit, dcache_ready, mem_br_taken
//   Controls out of the sequencer: pc_we, ifid_we, idex_we, exmem_we,
//     ifid_flush, idex_bubble, exmem_flush, memwb_bubble, pc_sel_br,
//     pc_sel_j, busy
// master = datapath side (drives status), slave = sequencer side.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = pipe_hazard_ctrl_pkg::REG_W
) ();

  logic             id_j;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rt;
  logic             mem_access;
  logic             dcache_hit;
  logic             dcache_ready;
  logic             mem_br_taken;

  logic pc_we;
  logic ifid_we;
  logic idex_we;
  logic exmem_we;
  logic ifid_flush;
  logic idex_bubble;
  logic exmem_flush;
  logic memwb_bubble;
  logic pc_sel_br;
  logic pc_sel_j;
  logic busy;

  modport master (
    output id_j, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           mem_access, dcache_hit, dcache_ready, mem_br_taken,
    input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble,
           exmem_flush, memwb_bubble, pc_sel_br, pc_sel_j, busy
  );

  modport slave (
    input  id_j, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           mem_access, dcache_hit, dcache_ready, mem_br_taken,
    output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble,
           exmem_flush, memwb_bubble, pc_sel_br, pc_sel_j, busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Pure combinational load-use comparator: flags an instruction in ID that
// needs the result of the lw currently in EX, which cannot be forwarded yet.
//   i_ex_memread  EX holds a lw
//   i_ex_rt       destination of that lw
//   i_id_rs       ID rs specifier (always a source)
//   i_id_rt       ID rt specifier
//   i_id_uses_rt  ID instruction reads rt
//   o_load_use    one-cycle stall required
// -----------------------------------------------------------------------------
module hazard_detect #(
  parameter int REG_W = pipe_hazard_ctrl_pkg::REG_W
) (
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  output logic             o_load_use
);

  // $0 is hard-wired zero, so a lw targeting it never creates a dependency.
  always_comb begin
    o_load_use = 1'b0;
    if (i_ex_memread && (i_ex_rt != {REG_W{1'b0}})) begin
      o_load_use = (i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt));
    end else begin
      o_load_use = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline sequencer: resolves data-cache misses, taken branches, load-use
// hazards and jumps (in that priority) by driving the stage write enables,
// flushes and bubbles. Outputs are combinational from state and inputs.
//   i_clk           clock, rising edge
//   i_rst           synchronous active-high reset
//   io_bus          pipe_hazard_ctrl_if.slave (status in, controls out)
//   o_stall_cycles  cycles with pc_we = 0 (PIPE_HAZARD_CTRL_PERF_EN only)
//   o_miss_count    RUN->MISS_WAIT transitions (PIPE_HAZARD_CTRL_PERF_EN only)
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN (saturating counters).
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_W = pipe_hazard_ctrl_pkg::REG_W,
  parameter int CNT_W = pipe_hazard_ctrl_pkg::CNT_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  pipe_hazard_ctrl_if.slave  io_bus
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   o_stall_cycles,
  output logic [CNT_W-1:0]   o_miss_count
`endif
);

  import pipe_hazard_ctrl_pkg::*;

  state_e r_state;
  state_e w_state_nxt;
  logic   r_rst_q;     // high on the first cycle after reset is released
  logic   w_rst_win;   // reset cycles plus that first cycle
  logic   w_miss;
  logic   w_load_use;

  logic w_pc_we, w_ifid_we, w_idex_we, w_exmem_we;
  logic w_ifid_flush, w_idex_bubble, w_exmem_flush, w_memwb_bubble;
  logic w_pc_sel_br, w_pc_sel_j;

  assign w_rst_win = i_rst | r_rst_q;
  assign w_miss    = io_bus.mem_access & ~io_bus.dcache_hit;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .i_ex_memread (io_bus.ex_memread),
    .i_ex_rt      (io_bus.ex_rt),
    .i_id_rs      (io_bus.id_rs),
    .i_id_rt      (io_bus.id_rt),
    .i_id_uses_rt (io_bus.id_uses_rt),
    .o_load_use   (w_load_use)
  );

  // State register and post-reset marker.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RUN;
      r_rst_q <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_rst_q <= 1'b0;
    end
  end

  // Next state and stage controls, highest-priority event first.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_we        = 1'b1;
    w_ifid_we      = 1'b1;
    w_idex_we      = 1'b1;
    w_exmem_we     = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_bubble  = 1'b0;
    w_exmem_flush  = 1'b0;
    w_memwb_bubble = 1'b0;
    w_pc_sel_br    = 1'b0;
    w_pc_sel_j     = 1'b0;
    if (w_rst_win) begin
      // Hold every stage and fill the pipe with NOPs until reset has settled.
      w_state_nxt    = RUN;
      w_pc_we        = 1'b0;
      w_ifid_we      = 1'b0;
      w_idex_we      = 1'b0;
      w_exmem_we     = 1'b0;
      w_ifid_flush   = 1'b1;
      w_idex_bubble  = 1'b1;
      w_exmem_flush  = 1'b1;
      w_memwb_bubble = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_miss) begin
            w_state_nxt    = MISS_WAIT;
            w_pc_we        = 1'b0;
            w_ifid_we      = 1'b0;
            w_idex_we      = 1'b0;
            w_exmem_we     = 1'b0;
            w_memwb_bubble = 1'b1;
          end else if (io_bus.mem_br_taken) begin
            // The three younger instructions are on the wrong path.
            w_pc_sel_br   = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            w_exmem_flush = 1'b1;
          end else if (w_load_use) begin
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_idex_bubble = 1'b1;
          end else if (io_bus.id_j) begin
            w_pc_sel_j   = 1'b1;
            w_ifid_flush = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
        MISS_WAIT: begin
          w_pc_we    = 1'b0;
          w_ifid_we  = 1'b0;
          w_idex_we  = 1'b0;
          w_exmem_we = 1'b0;
          if (io_bus.dcache_ready) begin
            // Only MEM/WB captures the refilled data here; upstream stages
            // resume on the following cycle, where any held branch or jump
            // is then resolved.
            w_state_nxt    = RUN;
            w_memwb_bubble = 1'b0;
          end else begin
            w_state_nxt    = MISS_WAIT;
            w_memwb_bubble = 1'b1;
          end
        end
        default: begin
          w_state_nxt    = RUN;
          w_pc_we        = 1'b0;
          w_ifid_we      = 1'b0;
          w_idex_we      = 1'b0;
          w_exmem_we     = 1'b0;
          w_memwb_bubble = 1'b1;
        end
      endcase
    end
  end

  assign io_bus.pc_we        = w_pc_we;
  assign io_bus.ifid_we      = w_ifid_we;
  assign io_bus.idex_we      = w_idex_we;
  assign io_bus.exmem_we     = w_exmem_we;
  assign io_bus.ifid_flush   = w_ifid_flush;
  assign io_bus.idex_bubble  = w_idex_bubble;
  assign io_bus.exmem_flush  = w_exmem_flush;
  assign io_bus.memwb_bubble = w_memwb_bubble;
  assign io_bus.pc_sel_br    = w_pc_sel_br;
  assign io_bus.pc_sel_j     = w_pc_sel_j;
  assign io_bus.busy         = (r_state == MISS_WAIT) & ~w_rst_win;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_miss_count;
  logic             w_miss_entry;

  assign w_miss_entry = (r_state == RUN) && (w_state_nxt == MISS_WAIT);

  // Saturating performance counters; reset-induced holds are not stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= {CNT_W{1'b0}};
      r_miss_count   <= {CNT_W{1'b0}};
    end else begin
      if (!r_rst_q && !w_pc_we && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_miss_entry && (r_miss_count != {CNT_W{1'b1}})) begin
        r_miss_count <= r_miss_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_stall_cycles = i_rst ? {CNT_W{1'b0}} : r_stall_cycles;
  assign o_miss_count   = i_rst ? {CNT_W{1'b0}} : r_miss_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl. Inputs change on the falling edge;
// outputs are sampled 1 ns later. A behavioural model classifies each cycle
// into the event it should produce and yields the expected control vector
// {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, exmem_flush,
//  memwb_bubble, pc_sel_br, pc_sel_j, busy}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 32;

  // Expected control vectors, one per pipeline situation.
  localparam logic [10:0] V_RESET  = 11'b0000_1111_000;
  localparam logic [10:0] V_NORM   = 11'b1111_0000_000;
  localparam logic [10:0] V_FRZ0   = 11'b0000_0001_000;  // miss detected in RUN
  localparam logic [10:0] V_FRZ1   = 11'b0000_0001_001;  // waiting for refill
  localparam logic [10:0] V_READY  = 11'b0000_0000_001;  // refill captured
  localparam logic [10:0] V_BRANCH = 11'b1111_1110_100;
  localparam logic [10:0] V_LDUSE  = 11'b0011_0100_000;
  localparam logic [10:0] V_JUMP   = 11'b1111_1000_010;

  typedef struct packed {
    logic          rst;
    logic          j;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          uses_rt;
    logic          memread;
    logic [RW-1:0] ex_rt;
    logic          access;
    logic          hit;
    logic          ready;
    logic          br;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_W(RW)) bus ();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] miss_count;
  pipe_hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .io_bus(bus),
    .o_stall_cycles(stall_cycles), .o_miss_count(miss_count));
`else
  pipe_hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .io_bus(bus));
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: current values and values for after the next rising edge.
  logic        m_wait, m_nwait, m_post, m_npost;
  logic [CW-1:0] m_stall, m_nstall, m_miss, m_nmiss;
  logic [10:0] m_exp;
  logic [CW-1:0] m_exp_stall, m_exp_miss;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.hit = 1'b1;
    return s;
  endfunction

  function automatic logic [10:0] obs_vec();
    return {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we,
            bus.ifid_flush, bus.idex_bubble, bus.exmem_flush, bus.memwb_bubble,
            bus.pc_sel_br, bus.pc_sel_j, bus.busy};
  endfunction

  // Classify the cycle by the priority rules and produce the expectation.
  task automatic predict(input stim_t s);
    logic lu;
    logic miss;
    lu   = s.memread && (s.ex_rt != 5'd0) &&
           ((s.ex_rt == s.rs) || (s.uses_rt && (s.ex_rt == s.rt)));
    miss = s.access && !s.hit;
    m_nwait = m_wait;
    m_npost = 1'b0;
    m_nstall = m_stall;
    m_nmiss  = m_miss;
    if (s.rst) begin
      m_exp = V_RESET; m_nwait = 1'b0; m_npost = 1'b1;
      m_nstall = '0; m_nmiss = '0;
    end else if (m_post) begin
      m_exp = V_RESET;
    end else if (m_wait) begin
      if (s.ready) begin m_exp = V_READY; m_nwait = 1'b0; end
      else m_exp = V_FRZ1;
    end else if (miss) begin
      m_exp = V_FRZ0; m_nwait = 1'b1;
      if (m_miss != '1) m_nmiss = m_miss + 1;
    end else if (s.br) m_exp = V_BRANCH;
    else if (lu)       m_exp = V_LDUSE;
    else if (s.j)      m_exp = V_JUMP;
    else               m_exp = V_NORM;
    if (!s.rst && !m_post && !m_exp[10] && (m_stall != '1)) m_nstall = m_stall + 1;
    m_exp_stall = s.rst ? '0 : m_stall;
    m_exp_miss  = s.rst ? '0 : m_miss;
  endtask

  // Advance one cycle: commit the model, drive inputs, let outputs settle.
  task automatic tick(input stim_t s);
    @(negedge clk);
    m_wait = m_nwait; m_post = m_npost; m_stall = m_nstall; m_miss = m_nmiss;
    rst = s.rst;
    bus.id_j = s.j; bus.id_rs = s.rs; bus.id_rt = s.rt; bus.id_uses_rt = s.uses_rt;
    bus.ex_memread = s.memread; bus.ex_rt = s.ex_rt; bus.mem_access = s.access;
    bus.dcache_hit = s.hit; bus.dcache_ready = s.ready; bus.mem_br_taken = s.br;
    #1;
    predict(s);
  endtask

  task automatic test_reset();
    stim_t s;
    s = idle();
    for (int k = 0; k < 5; k++) begin
      s.rst = (k < 3);
      tick(s);
      n_checks++;
      if (obs_vec() !== m_exp) begin
        n_fails++;
        $display("FAIL reset step %0d: got %b expected %b", k, obs_vec(), m_exp);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    for (int k = 0; k < 6; k++) begin
      s = idle();
      case (k)
        0: begin s.memread = 1'b1; s.ex_rt = 5'd5; s.rs = 5'd5; s.rt = 5'd2; s.uses_rt = 1'b1; end
        1: begin s.rs = 5'd5; s.rt = 5'd2; s.uses_rt = 1'b1; end  // lw moved on
        2: begin s.memread = 1'b1; s.ex_rt = 5'd7; s.rs = 5'd3; s.rt = 5'd7; s.uses_rt = 1'b1; end
        3: begin s.memread = 1'b1; s.ex_rt = 5'd7; s.rs = 5'd3; s.rt = 5'd7; s.uses_rt = 1'b0; end
        4: begin s.memread = 1'b1; s.ex_rt = 5'd0; s.rs = 5'd0; s.rt = 5'd0; s.uses_rt = 1'b1; end
        default: begin s.memread = 1'b1; s.ex_rt = 5'd9; s.rs = 5'd9; s.j = 1'b1; end
      endcase
      tick(s);
      n_checks++;
      if (obs_vec() !== m_exp) begin
        n_fails++;
        $display("FAIL load_use step %0d: got %b expected %b", k, obs_vec(), m_exp);
      end
    end
  endtask

  task automatic test_miss();
    stim_t s;
    int frz, bsy;
    logic [CW-1:0] st0, ms0;
    frz = 0; bsy = 0; st0 = '0; ms0 = '0;
    for (int k = 0; k < 10; k++) begin
      s = idle();
      s.access = 1'b1;
      s.hit    = (k >= 8);
      s.ready  = (k == 7);
      tick(s);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      if (k == 0) begin st0 = stall_cycles; ms0 = miss_count; end
      if (k == 9) begin
        n_checks++;
        if (stall_cycles - st0 !== 32'd8 || miss_count - ms0 !== 32'd1) begin
          n_fails++;
          $display("FAIL miss_counters: got stall+%0d miss+%0d expected 8 and 1",
                   stall_cycles - st0, miss_count - ms0);
        end
      end
`endif
      if (k < 9) begin
        if (!bus.pc_we) frz++;
        if (bus.busy) bsy++;
      end
      n_checks++;
      if (obs_vec() !== m_exp) begin
        n_fails++;
        $display("FAIL miss step %0d: got %b expected %b", k, obs_vec(), m_exp);
      end
    end
    n_checks++;
    if (frz != 8 || bsy != 7) begin
      n_fails++;
      $display("FAIL miss_length: got freeze %0d busy %0d expected 8 and 7", frz, bsy);
    end
  endtask

  task automatic test_branch_jump();
    stim_t s;
    for (int k = 0; k < 4; k++) begin
      s = idle();
      case (k)
        0: begin s.br = 1'b1; s.j = 1'b1; end
        1: begin s.br = 1'b1; s.memread = 1'b1; s.ex_rt = 5'd4; s.rs = 5'd4; end
        2: begin s.j = 1'b1; end
        default: begin s.br = 1'b1; s.access = 1'b1; s.hit = 1'b0; end  // miss wins
      endcase
      tick(s);
      n_checks++;
      if (obs_vec() !== m_exp) begin
        n_fails++;
        $display("FAIL branch_jump step %0d: got %b expected %b", k, obs_vec(), m_exp);
      end
    end
    s = idle(); s.ready = 1'b1;
    tick(s);  // release the miss left by the last step
  endtask

  task automatic test_branch_in_miss();
    stim_t s;
    for (int k = 0; k < 7; k++) begin
      s = idle();
      s.access = 1'b1;
      s.hit    = (k >= 5);
      s.br     = (k >= 1 && k <= 5);
      s.ready  = (k == 4);
      tick(s);
      n_checks++;
      if (obs_vec() !== m_exp) begin
        n_fails++;
        $display("FAIL branch_in_miss step %0d: got %b expected %b", k, obs_vec(), m_exp);
      end
    end
  endtask

  task automatic test_reset_mid_miss();
    stim_t s;
    for (int k = 0; k < 7; k++) begin
      s = idle();
      s.access = (k < 4);
      s.hit    = (k >= 4);
      s.rst    = (k == 3);
      s.ready  = (k == 5);
      tick(s);
      n_checks++;
      if (obs_vec() !== m_exp) begin
        n_fails++;
        $display("FAIL reset_mid_miss step %0d: got %b expected %b", k, obs_vec(), m_exp);
      end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      if (k >= 3) begin
        n_checks++;
        if (stall_cycles !== m_exp_stall || miss_count !== m_exp_miss) begin
          n_fails++;
          $display("FAIL reset_counters step %0d: got %0d/%0d expected %0d/%0d",
                   k, stall_cycles, miss_count, m_exp_stall, m_exp_miss);
        end
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    for (int k = 0; k < 8; k++) begin
      s = idle();
      s.access = 1'b1;
      s.hit    = (k >= 7);
      s.ready  = (k == 2 || k == 5);
      tick(s);
      n_checks++;
      if (obs_vec() !== m_exp) begin
        n_fails++;
        $display("FAIL back_to_back step %0d: got %b expected %b", k, obs_vec(), m_exp);
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int k = 0; k < 400; k++) begin
      s.rst     = ($urandom_range(0, 99) == 0);
      s.j       = ($urandom_range(0, 5) == 0);
      s.rs      = 5'($urandom_range(0, 6));
      s.rt      = 5'($urandom_range(0, 6));
      s.uses_rt = 1'($urandom_range(0, 1));
      s.memread = ($urandom_range(0, 2) == 0);
      s.ex_rt   = 5'($urandom_range(0, 6));
      s.access  = 1'($urandom_range(0, 1));
      s.hit     = ($urandom_range(0, 5) != 0);
      s.ready   = ($urandom_range(0, 3) == 0);
      s.br      = ($urandom_range(0, 5) == 0);
      tick(s);
      n_checks++;
      if (obs_vec() !== m_exp) begin
        n_fails++;
        $display("FAIL random cycle %0d: got %b expected %b", k, obs_vec(), m_exp);
      end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      n_checks++;
      if (stall_cycles !== m_exp_stall || miss_count !== m_exp_miss) begin
        n_fails++;
        $display("FAIL random_counters cycle %0d: got %0d/%0d expected %0d/%0d",
                 k, stall_cycles, miss_count, m_exp_stall, m_exp_miss);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.id_j = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.ex_memread = 1'b0; bus.ex_rt = '0; bus.mem_access = 1'b0;
    bus.dcache_hit = 1'b1; bus.dcache_ready = 1'b0; bus.mem_br_taken = 1'b0;
    m_wait = 1'b0; m_nwait = 1'b0; m_post = 1'b0; m_npost = 1'b0;
    m_stall = '0; m_nstall = '0; m_miss = '0; m_nmiss = '0;
    m_exp = V_RESET; m_exp_stall = '0; m_exp_miss = '0;
    test_reset();
    test_load_use();
    test_miss();
    test_branch_jump();
    test_branch_in_miss();
    test_reset_mid_miss();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
